// File: rtl/memwb_stage_pkg.sv
// memwb_stage_pkg: shared CPU definitions used by the MEM/WB stage.
//   - load type encodings carried on in_loadtype (LT_LW..LT_LHU)
//   - MEM/WB load-wait FSM state encodings
package memwb_stage_pkg;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } memwb_state_t;

endpackage

// File: rtl/memwb_stage_load_extend.sv
// load_extend: combinational sub-word extraction for loads.
//   rdata    in  32  raw word returned by data memory
//   offset   in   2  byte offset (load address bits [1:0])
//   loadtype in   3  LT_* encoding; unused codes behave as LW
//   result   out 32  extracted, sign/zero-extended value
// Alignment is not checked; LH/LHU look only at offset[1].
module load_extend
  import memwb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadtype,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (loadtype)
      LT_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  result = {24'h000000, byte_sel};
      LT_LH:   result = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  result = {16'h0000, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memwb_stage.sv
// memwb_stage: MEM/WB pipeline stage with load-return wait.
// Non-loads commit one cycle after acceptance; loads park in WAIT until
// data_ok returns the read data, which is extended and committed.
//   clk, rst (async, active-high)
//   in_valid/in_regwrite/in_memtoreg/in_writereg/in_aluout/in_loadtype: MEM inputs
//   stall, flush: hazard-unit controls
//   data_ok, data_rdata: data-memory read return
//   busy: stage waiting on load data
//   regwrite_w, writereg_w, result_w: GPR write port (one-cycle pulse)
// Macro MEMWB_LOAD_EXT_EN: when defined, byte/halfword extraction is
// built; otherwise loads write data_rdata unmodified.
//
// state | meaning
// IDLE  | ready to accept an instruction
// WAIT  | load issued, waiting for data_ok to commit
// DROP  | load flushed, waiting for data_ok to discard
module memwb_stage
  import memwb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_regwrite,
  input  logic        in_memtoreg,
  input  logic [4:0]  in_writereg,
  input  logic [31:0] in_aluout,
  input  logic [2:0]  in_loadtype,
  input  logic        stall,
  input  logic        flush,
  input  logic        data_ok,
  input  logic [31:0] data_rdata,
  output logic        busy,
  output logic        regwrite_w,
  output logic [4:0]  writereg_w,
  output logic [31:0] result_w
);

  memwb_state_t state, state_nxt;
  logic         accept;
  logic         ld_regwrite;
  logic [4:0]   ld_writereg;
  logic [31:0]  ext_data;

  assign busy   = (state != ST_IDLE);
  assign accept = in_valid & ~stall & ~busy & ~flush;

`ifdef MEMWB_LOAD_EXT_EN
  logic [1:0] ld_offset;
  logic [2:0] ld_loadtype;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_offset   <= 2'd0;
      ld_loadtype <= LT_LW;
    end else if (accept && in_memtoreg) begin
      ld_offset   <= in_aluout[1:0];
      ld_loadtype <= in_loadtype;
    end
  end

  load_extend u_load_extend (
    .rdata    (data_rdata),
    .offset   (ld_offset),
    .loadtype (ld_loadtype),
    .result   (ext_data)
  );
`else
  logic unused_loadtype;
  assign unused_loadtype = ^in_loadtype;
  assign ext_data        = data_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Flush with data_ok in the same WAIT cycle has nothing left to drop.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && in_memtoreg) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (flush)        state_nxt = data_ok ? ST_IDLE : ST_DROP;
        else if (data_ok) state_nxt = ST_IDLE;
      end
      ST_DROP: if (data_ok) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_regwrite <= 1'b0;
      ld_writereg <= 5'd0;
    end else if (accept && in_memtoreg) begin
      ld_regwrite <= in_regwrite;
      ld_writereg <= in_writereg;
    end
  end

  // Output registers only move on a real commit so they hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_w <= 1'b0;
      writereg_w <= 5'd0;
      result_w   <= 32'd0;
    end else begin
      regwrite_w <= 1'b0;
      if (accept && !in_memtoreg && in_regwrite && (in_writereg != 5'd0)) begin
        regwrite_w <= 1'b1;
        writereg_w <= in_writereg;
        result_w   <= in_aluout;
      end else if ((state == ST_WAIT) && data_ok && !flush &&
                   ld_regwrite && (ld_writereg != 5'd0)) begin
        regwrite_w <= 1'b1;
        writereg_w <= ld_writereg;
        result_w   <= ext_data;
      end
    end
  end

endmodule
